// File: rtl/delay_addr_gen.sv
// delay_addr_gen: address generator for a RAM-based sample delay line.
// Each accepted sample is written at the write pointer. The read address trails
// the write pointer by the requested delay. A small FSM (IDLE/FILL/RUN) tracks
// whether the delay line has been filled since reset or since the last delay change.
// Optional build macro FILL_GATE_EN: when defined, out_valid is suppressed until
// the state after the accepting edge is RUN.
module delay_addr_gen #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic [DATA_WIDTH-1:0]    mic_in,
  output logic [ADDRESS_WIDTH-1:0] write_addr,
  output logic [ADDRESS_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0]    data_in,
  output logic                     fill_done,
  output logic                     out_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] L_ONE = ADDRESS_WIDTH'(1);

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_delay_q;
  logic [ADDRESS_WIDTH-1:0] r_fill_cnt;
  logic [ADDRESS_WIDTH-1:0] r_write_addr;
  logic [ADDRESS_WIDTH-1:0] r_read_addr;
  logic [DATA_WIDTH-1:0]    r_data_in;
  logic                     r_fill_done;
  logic                     r_pend;
  logic                     r_out_valid;

  logic [ADDRESS_WIDTH-1:0] w_delay_eff;
  logic [ADDRESS_WIDTH-1:0] w_fill_cnt_inc;
  logic                     w_restart;
  logic                     w_fill_last;
  logic                     w_run_next;
  logic                     w_qual;

  // A zero delay would read the word being written this cycle, so clamp to 1.
  assign w_delay_eff    = (delay == '0) ? L_ONE : delay;
  assign w_fill_cnt_inc = r_fill_cnt + L_ONE;

  // Leaving IDLE and a delay change both restart the fill; a restart wins over FILL->RUN.
  assign w_restart   = (r_state == S_IDLE) || (w_delay_eff != r_delay_q);
  assign w_fill_last = (r_state == S_FILL) && (w_fill_cnt_inc == r_delay_q);
  assign w_run_next  = !w_restart && ((r_state == S_RUN) || w_fill_last);

`ifdef FILL_GATE_EN
  // Only samples accepted into a filled line produce a valid read.
  assign w_qual = en && w_run_next;
`else
  // Every accepted sample produces a read strobe, stale or not.
  assign w_qual = en;
`endif

  // FSM, address/data registers and the two-stage out_valid pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_delay_q    <= '0;
      r_fill_cnt   <= '0;
      r_write_addr <= '0;
      r_read_addr  <= '0;
      r_data_in    <= '0;
      r_fill_done  <= 1'b0;
      r_pend       <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      // RAM read data arrives one cycle after the read address register updates.
      r_pend      <= w_qual;
      r_out_valid <= r_pend;
      if (en) begin
        r_write_addr <= r_wr_ptr;
        r_data_in    <= mic_in;
        r_read_addr  <= r_wr_ptr - w_delay_eff;
        r_wr_ptr     <= r_wr_ptr + L_ONE;
        r_fill_done  <= w_run_next;
        if (w_restart) begin
          r_delay_q  <= w_delay_eff;
          r_fill_cnt <= '0;
          r_state    <= S_FILL;
        end else if (r_state == S_FILL) begin
          r_fill_cnt <= w_fill_cnt_inc;
          if (w_fill_last) begin
            r_state <= S_RUN;
          end
        end
      end
    end
  end

  assign write_addr = r_write_addr;
  assign read_addr  = r_read_addr;
  assign data_in    = r_data_in;
  assign fill_done  = r_fill_done;
  assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_delay_addr_gen.sv
// tb_delay_addr_gen: directed test of delay_addr_gen (ADDRESS_WIDTH=9, DATA_WIDTH=8).
module tb_delay_addr_gen;

`ifdef FILL_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic [8:0] delay;
  logic [7:0] mic_in;
  logic [8:0] write_addr;
  logic [8:0] read_addr;
  logic [7:0] data_in;
  logic       fill_done;
  logic       out_valid;

  int errors = 0;
  int checks = 0;
  int exp_wr = 0;
  int exp_wa = 0;
  int exp_ra = 0;
  int exp_data = 0;
  int mic_val = 8'h11;

  delay_addr_gen #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .delay     (delay),
    .mic_in    (mic_in),
    .write_addr(write_addr),
    .read_addr (read_addr),
    .data_in   (data_in),
    .fill_done (fill_done),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, observe 1 ns after the rising edge.
  task automatic do_edge(input logic en_v);
    @(negedge clk);
    en     = en_v;
    mic_in = 8'(mic_val);
    @(posedge clk);
    #1;
    $display("t=%0t en=%0b delay=%0d wa=%0d ra=%0d din=%0d fd=%0b ov=%0b",
             $time, en_v, delay, write_addr, read_addr, data_in, fill_done, out_valid);
  endtask

  // Accepted sample with effective delay d: checks address, read offset and data.
  task automatic en_step(input int d, input string tag);
    do_edge(1'b1);
    exp_wa   = exp_wr;
    exp_ra   = (exp_wr - d) & 511;
    exp_data = mic_val & 255;
    chk({tag, ".wa"}, int'(write_addr), exp_wa);
    chk({tag, ".ra"}, int'(read_addr), exp_ra);
    chk({tag, ".din"}, int'(data_in), exp_data);
    exp_wr  = (exp_wr + 1) & 511;
    mic_val = (mic_val * 5 + 3) & 255;
  endtask

  // Idle cycle: every address/data output must hold.
  task automatic idle_step(input string tag);
    do_edge(1'b0);
    chk({tag, ".wa_hold"}, int'(write_addr), exp_wa);
    chk({tag, ".ra_hold"}, int'(read_addr), exp_ra);
    chk({tag, ".din_hold"}, int'(data_in), exp_data);
  endtask

  initial begin
    rst    = 1'b0;
    en     = 1'b0;
    delay  = 9'd4;
    mic_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.wa", int'(write_addr), 0);
    chk("rst.ra", int'(read_addr), 0);
    chk("rst.din", int'(data_in), 0);
    chk("rst.fd", int'(fill_done), 0);
    chk("rst.ov", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b1;

    // Fill with delay 4: edge 1 enters FILL, four more edges reach RUN.
    for (int k = 1; k <= 5; k++) begin
      en_step(4, "fill4");
      chk("fill4.fd", int'(fill_done), (k >= 5) ? 1 : 0);
      chk("fill4.ov", int'(out_valid), GATE ? 0 : ((k >= 2) ? 1 : 0));
    end

    // Long run across the pointer wrap; read offset stays 4.
    for (int k = 0; k < 600; k++) begin
      en_step(4, "wrap");
      chk("wrap.fd", int'(fill_done), 1);
      chk("wrap.ov", int'(out_valid), 1);
    end

    // Delay change 4 -> 10 in RUN: offset 10 at once, refill takes 10 more edges.
    delay = 9'd10;
    en_step(10, "chg10");
    chk("chg10.fd", int'(fill_done), 0);
    for (int k = 1; k <= 10; k++) begin
      en_step(10, "refill10");
      chk("refill10.fd", int'(fill_done), (k == 10) ? 1 : 0);
    end

    // Delay 0 behaves as 1: offset 1, RUN after one further edge.
    delay = 9'd0;
    en_step(1, "d0");
    chk("d0.fd", int'(fill_done), 0);
    en_step(1, "d0run");
    chk("d0run.fd", int'(fill_done), 1);

    // Sparse enables: one pulse per en, visible on the second edge after it.
    idle_step("drain");
    idle_step("drain");
    chk("drain.ov", int'(out_valid), 0);
    for (int g = 0; g < 4; g++) begin
      en_step(1, "sparse");
      chk("sparse.ov0", int'(out_valid), 0);
      idle_step("sparse_i1");
      chk("sparse.ov1", int'(out_valid), 1);
      idle_step("sparse_i2");
      chk("sparse.ov2", int'(out_valid), 0);
    end

    // Reset mid-FILL with a pulse in flight.
    delay = 9'd7;
    en_step(7, "pre_rst");
    chk("pre_rst.fd", int'(fill_done), 0);
    rst = 1'b0;
    #1;
    chk("async_rst.wa", int'(write_addr), 0);
    chk("async_rst.ra", int'(read_addr), 0);
    chk("async_rst.din", int'(data_in), 0);
    chk("async_rst.fd", int'(fill_done), 0);
    chk("async_rst.ov", int'(out_valid), 0);
    do_edge(1'b0);
    chk("in_rst.ov", int'(out_valid), 0);
    do_edge(1'b0);
    chk("in_rst.ov2", int'(out_valid), 0);
    @(negedge clk);
    rst    = 1'b1;
    exp_wr = 0;

    // Restart from IDLE: pointer from 0, a full 7-sample fill before RUN.
    for (int k = 1; k <= 8; k++) begin
      en_step(7, "restart");
      chk("restart.fd", int'(fill_done), (k == 8) ? 1 : 0);
    end
    do_edge(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
